pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_counter.sv | 28 ++
 rtl/pwm_fade_ctrl.sv | 128 ++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: FSM encoding and minimum period.
package pwm_pkg;

   localparam int PERIOD_MIN = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RAMP  = 2'd2
   } fade_state_e;

endpackage

// File: rtl/pwm_counter.sv
// Free-running PWM period counter with wrap, period_end pulse and duty compare.
// Outputs are combinational from the registered count.
module pwm_counter #(
   parameter int CNT_W = 28
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] duty_i,
   output logic             period_end_o,
   output logic             pwm_o
);

   logic [CNT_W-1:0] count_q, count_d;

   assign period_end_o = (count_q == period_i - CNT_W'(1));
   assign pwm_o        = (count_q < duty_i);
   assign count_d      = period_end_o ? '0 : count_q + CNT_W'(1);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM generator whose duty ramps toward a loaded target by a fixed step per period.
// Period and duty only change on period_end, so every period is internally consistent.
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int CNT_W  = 28,
   parameter int STEP_W = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_target,
   input  logic [STEP_W-1:0] cfg_step,
   input  logic              cfg_load,
   output logic              pwm_out,
   output logic              period_end,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  duty_now
);

   localparam logic [CNT_W-1:0] PMIN = CNT_W'(PERIOD_MIN);
   localparam int W1 = CNT_W + 1;

   // One extra bit keeps cur+step and cur-target free of wrap/underflow.
   function automatic logic [CNT_W-1:0] ramp_toward(
      input logic [CNT_W-1:0]  cur,
      input logic [CNT_W-1:0]  tgt,
      input logic [STEP_W-1:0] stp
   );
      logic [W1-1:0] c, t, s;
      c = W1'(cur);
      t = W1'(tgt);
      s = W1'(stp);
      if (stp == '0)   return tgt;
      if (c < t)       return (c + s >= t) ? tgt : CNT_W'(c + s);
      if (c - t <= s)  return tgt;
      return CNT_W'(c - s);
   endfunction

   fade_state_e       state_q, state_d;
   logic [CNT_W-1:0]  sh_period_q, sh_period_d;
   logic [CNT_W-1:0]  sh_target_q, sh_target_d;
   logic [STEP_W-1:0] sh_step_q, sh_step_d;
   logic [CNT_W-1:0]  act_period_q, act_period_d;
   logic [CNT_W-1:0]  act_duty_q, act_duty_d;
   logic              done_q, done_d;

   logic [CNT_W-1:0]  ramp_duty, next_duty, ld_period, ld_target;

   assign ramp_duty = ramp_toward(act_duty_q, sh_target_q, sh_step_q);
   assign next_duty = (ramp_duty > sh_period_q) ? sh_period_q : ramp_duty;
   assign ld_period = (cfg_period < PMIN) ? PMIN : cfg_period;
   assign ld_target = (cfg_target > ld_period) ? ld_period : cfg_target;

   always_comb begin
      state_d      = state_q;
      sh_period_d  = sh_period_q;
      sh_target_d  = sh_target_q;
      sh_step_d    = sh_step_q;
      act_period_d = act_period_q;
      act_duty_d   = act_duty_q;
      done_d       = 1'b0;

      if (period_end) begin
         case (state_q)
            ARMED: begin
               act_period_d = sh_period_q;
               act_duty_d   = next_duty;
               state_d      = RAMP;
            end
            RAMP: begin
               if (act_duty_q == sh_target_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  act_period_d = sh_period_q;
                  act_duty_d   = next_duty;
               end
            end
            default: ;
         endcase
      end

      // A load coinciding with period_end lands after that update and re-arms.
      if (cfg_load) begin
         sh_period_d = ld_period;
         sh_target_d = ld_target;
         sh_step_d   = cfg_step;
         state_d     = ARMED;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         sh_period_q  <= PMIN;
         sh_target_q  <= '0;
         sh_step_q    <= '0;
         act_period_q <= PMIN;
         act_duty_q   <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_period_q  <= sh_period_d;
         sh_target_q  <= sh_target_d;
         sh_step_q    <= sh_step_d;
         act_period_q <= act_period_d;
         act_duty_q   <= act_duty_d;
         done_q       <= done_d;
      end
   end

   pwm_counter #(.CNT_W(CNT_W)) u_counter (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .period_i     (act_period_q),
      .duty_i       (act_duty_q),
      .period_end_o (period_end),
      .pwm_o        (pwm_out)
   );

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign duty_now = act_duty_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed scenarios plus random loads against a behavioural model.
module tb_pwm_fade_ctrl;

   localparam int CW = 8;
   localparam int SW = 8;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [CW-1:0] cfg_period = '0;
   logic [CW-1:0] cfg_target = '0;
   logic [SW-1:0] cfg_step = '0;
   logic          cfg_load = 1'b0;
   logic          pwm_out, period_end, busy, done;
   logic [CW-1:0] duty_now;

   always #5 CLK = ~CLK;

   pwm_fade_ctrl #(.CNT_W(CW), .STEP_W(SW)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .cfg_period (cfg_period),
      .cfg_target (cfg_target),
      .cfg_step   (cfg_step),
      .cfg_load   (cfg_load),
      .pwm_out    (pwm_out),
      .period_end (period_end),
      .busy       (busy),
      .done       (done),
      .duty_now   (duty_now)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: counter position, active settings, pending settings.
   int m_count = 0, m_period = 2, m_duty = 0;
   int m_sp = 2, m_tgt = 0, m_step = 0;
   bit m_busy = 0, m_ramping = 0, m_done = 0;
   bit pe_m, done_nx;

   function automatic int toward(int d, int t, int s);
      if (s == 0) return t;
      if (d < t)  return (d + s < t) ? d + s : t;
      return (d - s > t) ? d - s : t;
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_count = 0; m_period = 2; m_duty = 0;
         m_sp = 2; m_tgt = 0; m_step = 0;
         m_busy = 0; m_ramping = 0; m_done = 0;
      end else begin
         pe_m    = (m_count == m_period - 1);
         done_nx = 0;
         m_count = pe_m ? 0 : m_count + 1;
         if (pe_m && m_busy) begin
            if (m_ramping && m_duty == m_tgt) begin
               m_busy = 0; m_ramping = 0; done_nx = 1;
            end else begin
               m_period = m_sp;
               m_duty   = toward(m_duty, m_tgt, m_step);
               if (m_duty > m_period) m_duty = m_period;
               m_ramping = 1;
            end
         end
         if (cfg_load) begin
            m_sp   = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
            m_tgt  = (int'(cfg_target) > m_sp) ? m_sp : int'(cfg_target);
            m_step = int'(cfg_step);
            m_busy = 1; m_ramping = 0; done_nx = 0;
         end
         m_done = done_nx;
      end
   end

   always @(negedge CLK) begin
      check("flags{pwm,pe,busy,done}", {pwm_out, period_end, busy, done},
            {(m_count < m_duty), (m_count == m_period - 1), m_busy, m_done});
      check("duty_now", duty_now, m_duty);
   end

   task automatic load(input int p, input int t, input int s);
      @(posedge CLK); #1;
      cfg_period = CW'(p); cfg_target = CW'(t); cfg_step = SW'(s);
      cfg_load = 1'b1;
      @(posedge CLK); #1;
      cfg_load = 1'b0;
   endtask

   task automatic wait_pe();
      int n;
      n = 0;
      do begin @(negedge CLK); n++; end while (!period_end && n < 600);
      check("wait_period_end", period_end, 1);
   endtask

   task automatic next_duty(output int d);
      wait_pe();
      @(negedge CLK);
      d = duty_now;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin @(negedge CLK); n++; end while (!done && n < 600);
      check("done_seen", done, 1);
      check("busy_low_at_done", busy, 0);
   endtask

   task automatic do_reset();
      @(posedge CLK); #3;
      RST_N = 1'b0;
      #1;
      check("rst_pwm", pwm_out, 0);
      check("rst_period_end", period_end, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_duty", duty_now, 0);
      @(posedge CLK); @(posedge CLK); #1;
      RST_N = 1'b1;
   endtask

   initial begin
      int d, cnt;

      // Jump to duty 4 in a 10-clock period.
      do_reset();
      load(10, 4, 0);
      next_duty(d);
      check("s1_first_duty", d, 4);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge CLK);
         cnt += int'(pwm_out);
      end
      check("s1_high_clocks", cnt, 4);
      wait_done();
      cnt = 0;
      for (int i = 0; i < 25; i++) begin @(negedge CLK); cnt += int'(done); end
      check("s1_no_second_done", cnt, 0);

      // Ramp up 3, 6, 8 with saturation at the target.
      do_reset();
      load(8, 8, 3);
      next_duty(d); check("s2_duty_a", d, 3);
      next_duty(d); check("s2_duty_b", d, 6);
      next_duty(d); check("s2_duty_c", d, 8);
      wait_done();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin @(negedge CLK); cnt += int'(pwm_out); end
      check("s2_full_high", cnt, 8);

      // Redirect mid-ramp from duty 6 down to 1 in steps of 2.
      load(8, 6, 0);
      next_duty(d); check("s3_setup_duty", d, 6);
      load(8, 1, 2);
      check("s3_busy_after_reload", busy, 1);
      next_duty(d); check("s3_duty_a", d, 4); check("s3_busy_a", busy, 1);
      next_duty(d); check("s3_duty_b", d, 2); check("s3_busy_b", busy, 1);
      next_duty(d); check("s3_duty_c", d, 1); check("s3_busy_c", busy, 1);
      wait_done();

      // Period clamped to 2, target clamped to period.
      do_reset();
      load(0, 5, 0);
      next_duty(d); check("s4_duty", d, 2);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge CLK);
         check("s4_period_end_seq", period_end, i % 2);
         check("s4_pwm_high", pwm_out, 1);
      end

      // Load coinciding with period_end: old shadow first, new one next period.
      do_reset();
      load(4, 4, 0);
      cnt = 0;
      do begin @(posedge CLK); #1; cnt++; end while (!period_end && cnt < 50);
      check("s5_coincide", period_end, 1);
      cfg_period = CW'(6); cfg_target = CW'(1); cfg_step = '0; cfg_load = 1'b1;
      @(posedge CLK); #1;
      cfg_load = 1'b0;
      check("s5_old_applied", duty_now, 4);
      check("s5_still_busy", busy, 1);
      next_duty(d); check("s5_new_applied", d, 1);

      // Asynchronous reset in the middle of a ramp.
      do_reset();
      load(8, 8, 1);
      next_duty(d); check("s6_duty_a", d, 1);
      next_duty(d); check("s6_duty_b", d, 2);
      do_reset();
      load(10, 4, 0);
      next_duty(d); check("s6_after_reset", d, 4);
      wait_done();

      // Random loads, including wide values that exercise the extra ramp bit.
      for (int k = 0; k < 40; k++) begin
         int gap, p, t, s;
         gap = $urandom_range(0, 15);
         repeat (gap) @(posedge CLK);
         if ($urandom_range(0, 4) == 0) begin
            p = $urandom_range(150, 255);
            t = $urandom_range(0, 255);
            s = $urandom_range(100, 255);
         end else begin
            p = $urandom_range(0, 12);
            t = $urandom_range(0, 14);
            s = $urandom_range(0, 4);
         end
         load(p, t, s);
      end
      repeat (1500) @(posedge CLK);
      @(negedge CLK);
      check("random_settled_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
